// File: rtl/hb_pkg.sv
// Shared definitions for the Hummingbird core wrapper: word width, FSM state
// encoding and a saturating counter helper.
package hb_pkg;

    localparam int HB_WORD_W = 16;
    localparam int HB_CNT_W  = 8;

    typedef enum logic [1:0] {
        HB_IDLE  = 2'd0,
        HB_ISSUE = 2'd1,
        HB_WAIT  = 2'd2,
        HB_HOLD  = 2'd3
    } hb_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [HB_CNT_W-1:0] hb_sat_inc(input logic [HB_CNT_W-1:0] v);
        return (v == '1) ? v : v + HB_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hb_word_fifo.sv
// Small synchronous word FIFO. Full/empty come from an occupancy counter, so
// the pointers only need log2(FIFO_DEPTH) bits and simply wrap.
module hb_word_fifo
    import hb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [HB_WORD_W-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output logic [HB_WORD_W-1:0] rd_data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [HB_WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 do_wr;
    logic                 do_rd;

    assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign rd_data_o = mem_q[rd_ptr_q];

    // A read frees a slot in the same cycle, so a write alongside it is safe even when full.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; a reset discards whatever the buffer held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/hb_stream_sequencer.sv
// Host-side sequencer for the Hummingbird core: buffers plaintext words, hands
// them to the core one at a time, collects ciphertext and loop-back plaintext,
// and returns both on a valid/ready stream with mismatch and timeout reporting.
module hb_stream_sequencer
    import hb_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [HB_WORD_W-1:0] s_data,
    output logic                 hb_data_rdy,
    output logic [HB_WORD_W-1:0] hb_input_data,
    input  logic                 hb_enc_complete,
    input  logic                 hb_dec_complete,
    input  logic [HB_WORD_W-1:0] hb_enc_data,
    input  logic [HB_WORD_W-1:0] hb_dec_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [HB_WORD_W-1:0] m_cipher,
    output logic [HB_WORD_W-1:0] m_plain,
    output logic                 m_mismatch,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [HB_CNT_W-1:0]  mismatch_cnt
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    hb_state_e            state_q, state_d;
    logic                 ready_en_q;
    logic [HB_WORD_W-1:0] word_q, word_d;
    logic [HB_WORD_W-1:0] enc_q, enc_d;
    logic [HB_WORD_W-1:0] dec_q, dec_d;
    logic                 enc_seen_q, enc_seen_d;
    logic                 dec_seen_q, dec_seen_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 mism_q, mism_d;
    logic                 err_q, err_d;
    logic [HB_CNT_W-1:0]  cnt_q, cnt_d;

    logic                 fifo_wr;
    logic                 fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [HB_WORD_W-1:0] fifo_rd_data;

    logic                 both_seen;
    logic                 tmr_expired;
    logic [HB_WORD_W-1:0] dec_word;

    // s_ready is gated by a flop so it stays low until the first clock after reset release.
    assign s_ready = ready_en_q && !fifo_full;
    assign fifo_wr = s_valid && s_ready;
    assign fifo_rd = (state_q == HB_IDLE) && !fifo_empty;

    hb_word_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (s_data),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // A flag counts as seen if it was recorded earlier or is high at this edge.
    assign both_seen   = (enc_seen_q || hb_enc_complete) && (dec_seen_q || hb_dec_complete);
    assign tmr_expired = (timer_q == TMR_LAST);
    assign dec_word    = dec_seen_q ? dec_q : hb_dec_data;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one word in flight at a time, result held until the host takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HB_IDLE:  if (!fifo_empty) state_d = HB_ISSUE;
            HB_ISSUE: state_d = HB_WAIT;
            HB_WAIT:  if (both_seen || tmr_expired) state_d = HB_HOLD;
            HB_HOLD:  if (m_ready) state_d = HB_IDLE;
            default:  state_d = HB_IDLE;
        endcase
    end

    // FSM outputs, decoded purely from state and registered FIFO status.
    always_comb begin
        hb_data_rdy = (state_q == HB_ISSUE);
        m_valid     = (state_q == HB_HOLD);
        busy        = (state_q != HB_IDLE) || !fifo_empty;
    end

    // Datapath next-state: word load, flag/data capture, timer, result flags and counter.
    always_comb begin
        word_d     = word_q;
        enc_d      = enc_q;
        dec_d      = dec_q;
        enc_seen_d = enc_seen_q;
        dec_seen_d = dec_seen_q;
        timer_d    = timer_q;
        mism_d     = mism_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            HB_IDLE: begin
                // hb_input_data only ever changes here, so the core never sees it move mid-word.
                if (!fifo_empty) begin
                    word_d = fifo_rd_data;
                end
            end
            HB_ISSUE: begin
                // Flags still high from the previous word are deliberately not sampled here.
                timer_d    = '0;
                enc_seen_d = 1'b0;
                dec_seen_d = 1'b0;
                enc_d      = '0;
                dec_d      = '0;
                mism_d     = 1'b0;
            end
            HB_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                if (hb_enc_complete && !enc_seen_q) begin
                    enc_seen_d = 1'b1;
                    enc_d      = hb_enc_data;
                end
                if (hb_dec_complete && !dec_seen_q) begin
                    dec_seen_d = 1'b1;
                    dec_d      = hb_dec_data;
                end
                if (both_seen) begin
                    mism_d = (dec_word != word_q);
                    if (dec_word != word_q) begin
                        cnt_d = hb_sat_inc(cnt_q);
                    end
                end else if (tmr_expired) begin
                    // A timed-out word is reported as bad; fields never delivered stay zero.
                    err_d  = 1'b1;
                    mism_d = 1'b1;
                    cnt_d  = hb_sat_inc(cnt_q);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and status registers; everything clears on reset so outputs read zero at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
            word_q     <= '0;
            enc_q      <= '0;
            dec_q      <= '0;
            enc_seen_q <= 1'b0;
            dec_seen_q <= 1'b0;
            timer_q    <= '0;
            mism_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ready_en_q <= 1'b1;
            word_q     <= word_d;
            enc_q      <= enc_d;
            dec_q      <= dec_d;
            enc_seen_q <= enc_seen_d;
            dec_seen_q <= dec_seen_d;
            timer_q    <= timer_d;
            mism_q     <= mism_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign hb_input_data = word_q;
    assign m_cipher      = enc_q;
    assign m_plain       = dec_q;
    assign m_mismatch    = mism_q;
    assign err_timeout   = err_q;
    assign mismatch_cnt  = cnt_q;

endmodule

// File: tb/tb_hb_stream_sequencer.sv
// Bench for hb_stream_sequencer: a behavioural core model answers each issued
// word after programmable delays; expected results are queued on acceptance
// and compared in order as the sequencer returns them.
module tb_hb_stream_sequencer;
    import hb_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 64;
    localparam int NEVER = 1000000;

    logic        clk;
    logic        reset;
    logic        s_valid, s_ready;
    logic [15:0] s_data;
    logic        hb_data_rdy;
    logic [15:0] hb_input_data;
    logic        hb_enc_complete, hb_dec_complete;
    logic [15:0] hb_enc_data, hb_dec_data;
    logic        m_valid, m_ready;
    logic [15:0] m_cipher, m_plain;
    logic        m_mismatch, busy, err_timeout;
    logic [7:0]  mismatch_cnt;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] cipher;
        logic [15:0] plain;
        logic        mism;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_pass = 0;
    int   enc_dly, dec_dly;
    bit   corrupt;
    int   exp_cnt = 0;
    int   n_acc = 0, n_rdy = 0, n_res = 0, n_abort = 0;

    hb_stream_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .hb_data_rdy    (hb_data_rdy),
        .hb_input_data  (hb_input_data),
        .hb_enc_complete(hb_enc_complete),
        .hb_dec_complete(hb_dec_complete),
        .hb_enc_data    (hb_enc_data),
        .hb_dec_data    (hb_dec_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_cipher       (m_cipher),
        .m_plain        (m_plain),
        .m_mismatch     (m_mismatch),
        .busy           (busy),
        .err_timeout    (err_timeout),
        .mismatch_cnt   (mismatch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Core model: flags from the previous word stay high through ISSUE, then drop;
    // enc/dec rise enc_dly/dec_dly cycles after the hb_data_rdy cycle.
    int          k, c_enc, c_dec;
    bit          c_cor, active;
    logic [15:0] c_word;
    initial begin
        hb_enc_complete = 1'b0;
        hb_dec_complete = 1'b0;
        hb_enc_data     = '0;
        hb_dec_data     = '0;
        active          = 1'b0;
        k               = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                active          = 1'b0;
                hb_enc_complete = 1'b0;
                hb_dec_complete = 1'b0;
            end else if (hb_data_rdy) begin
                active = 1'b1;
                k      = 0;
                c_word = hb_input_data;
                c_enc  = enc_dly;
                c_dec  = dec_dly;
                c_cor  = corrupt;
            end else if (active) begin
                k++;
                if (k == 1) begin
                    hb_enc_complete = 1'b0;
                    hb_dec_complete = 1'b0;
                end
                if (k == c_enc) begin
                    hb_enc_complete = 1'b1;
                    hb_enc_data     = c_word ^ 16'hB791;
                end
                if (k == c_dec) begin
                    hb_dec_complete = 1'b1;
                    hb_dec_data     = c_cor ? 16'(c_word + 16'd1) : c_word;
                end
            end
        end
    end

    // Output monitor: issue order, input stability, one result per word.
    logic        prev_rdy = 1'b0;
    logic [15:0] last_in  = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_in  = hb_input_data;
                prev_rdy = 1'b0;
            end else begin
                if (hb_data_rdy) begin
                    n_rdy++;
                    chk("rdy_single_cycle", prev_rdy, 0);
                    if (sb_q.size() == 0) chk("issue_extra", hb_data_rdy, 0);
                    else chk("issue_word", hb_input_data, sb_q[0].word);
                end else if (hb_input_data !== last_in) begin
                    chk("in_stable", hb_input_data, last_in);
                end
                last_in  = hb_input_data;
                prev_rdy = hb_data_rdy;
                if (m_valid && m_ready) begin
                    n_res++;
                    if (sb_q.size() == 0) begin
                        chk("extra_result", m_valid, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("res_word", hb_input_data, e.word);
                        chk("res_cipher", m_cipher, e.cipher);
                        chk("res_plain", m_plain, e.plain);
                        chk("res_mismatch", m_mismatch, e.mism);
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] w);
        int   t;
        exp_t e;
        t = 0;
        while (!s_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 500) chk("s_ready_tmo", s_ready, 1);
        s_valid = 1'b1;
        s_data  = w;
        @(posedge clk);
        #1;
        s_valid  = 1'b0;
        e.word   = w;
        e.cipher = (enc_dly >= NEVER) ? 16'h0 : (w ^ 16'hB791);
        e.plain  = (dec_dly >= NEVER) ? 16'h0 : (corrupt ? 16'(w + 16'd1) : w);
        e.mism   = corrupt || (enc_dly >= NEVER) || (dec_dly >= NEVER);
        sb_q.push_back(e);
        n_acc++;
        if (e.mism && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((sb_q.size() != 0 || busy) && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, (t < 4000), 1);
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        enc_dly = 5;
        dec_dly = 7;
        corrupt = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_rdy", hb_data_rdy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_cnt", mismatch_cnt, 0);
        chk("rst_in_data", hb_input_data, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", s_ready, 1);

        // Single word: enc at +5, dec at +7.
        m_ready = 1'b1;
        send(16'h1234);
        drain("drain_single");
        chk("cnt_single", mismatch_cnt, exp_cnt);

        // Fill with the host stalled: one word sits in HOLD, four more fill the buffer.
        m_ready = 1'b0;
        enc_dly = 3;
        dec_dly = 4;
        for (int i = 0; i < 5; i++) send(16'h1000 + 16'(i));
        chk("fill_s_ready", s_ready, 0);
        chk("fill_busy", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("fill_still_full", s_ready, 0);
        chk("fill_holding", m_valid, 1);
        m_ready = 1'b1;
        drain("drain_fill");

        // Flag order: dec before enc, then both in the same cycle.
        enc_dly = 6;
        dec_dly = 3;
        send(16'h2222);
        drain("drain_dec_first");
        enc_dly = 4;
        dec_dly = 4;
        send(16'h3333);
        send(16'h3334);
        drain("drain_same_cycle");
        chk("cnt_good_words", mismatch_cnt, exp_cnt);

        // Corrupted loop-back, then enough bad words to saturate the counter.
        corrupt = 1'b1;
        enc_dly = 2;
        dec_dly = 3;
        send(16'h1234);
        drain("drain_bad1");
        chk("cnt_first_bad", mismatch_cnt, exp_cnt);
        enc_dly = 1;
        dec_dly = 1;
        for (int i = 0; i < 256; i++) send(16'(i * 7));
        drain("drain_bad256");
        chk("cnt_saturated", mismatch_cnt, exp_cnt);

        // Timeout: enc never completes.
        corrupt = 1'b0;
        enc_dly = NEVER;
        dec_dly = 3;
        send(16'h0F0F);
        n = 0;
        while (!hb_data_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_issue_seen", hb_data_rdy, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 200);
        // TIMEOUT_CYC cycles in WAIT, result visible on the cycle after.
        chk("tmo_latency", n, TMO + 1);
        chk("tmo_err", err_timeout, 1);
        drain("drain_tmo");
        chk("cnt_tmo", mismatch_cnt, exp_cnt);
        enc_dly = 2;
        dec_dly = 2;
        send(16'h4321);
        drain("drain_after_tmo");
        chk("err_sticky", err_timeout, 1);

        // Asynchronous reset in the middle of WAIT.
        enc_dly = 20;
        dec_dly = 20;
        send(16'h5555);
        n = 0;
        while (!hb_data_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        n_abort += sb_q.size();
        sb_q.delete();
        exp_cnt = 0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_in_data", hb_input_data, 0);
        chk("arst_err", err_timeout, 0);
        chk("arst_cnt", mismatch_cnt, 0);
        chk("arst_cipher", m_cipher, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        enc_dly = 2;
        dec_dly = 4;
        send(16'h0BAD);
        drain("drain_after_arst");
        chk("cnt_after_arst", mismatch_cnt, exp_cnt);
        chk("err_after_arst", err_timeout, 0);

        chk("rdy_pulses", n_rdy, n_acc);
        chk("result_count", n_res, n_acc - n_abort);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
